sparrow_encode: RTL and testbench
=================================

SPARROW_ENCODE -- requirements
Module: sparrow_encode

Interface
REQ-001 SHALL have port i_clk, input, 1, sole clock; all state on its rising edge.
REQ-002 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port i_valid, input, 1, encode request present.
REQ-004 SHALL have port o_ready, output, 1, block accepts a request this cycle.
REQ-005 SHALL have ports i_opcode (riscv_op_e, 7), i_rd (5), i_rs1 (5), i_rs2 (5), i_funct3 (3), i_funct7 (7) and i_imm (32), all inputs, carrying the request fields.
REQ-006 SHALL have port o_valid, output, 1, encoded word present.
REQ-007 SHALL have port i_ready, input, 1, consumer takes the word this cycle.
REQ-008 SHALL have port o_instr, output, 32, encoded RV32I instruction word.
REQ-009 SHALL have port o_err, output, 1, error flag accompanying o_instr.
REQ-010 SHALL have port o_err_count, output, 8, saturating count of errored words accepted by the consumer.

Function
REQ-011 SHALL accept a request on each cycle with i_valid && o_ready.
REQ-012 SHALL deliver a word on each cycle with o_valid && i_ready.
REQ-013 SHALL format by opcode class:
- R: {funct7, rs2, rs1, funct3, rd, op}.
- I_TYPE_0/1/2: {imm[11:0], rs1, funct3, rd, op}.
- S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
- B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
- U_TYPE_0/1: {imm[31:12], rd, op}.
- J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
REQ-014 SHALL ignore fields unused by the class; for example, funct7 is ignored for I-type and rs2 for U-type.
REQ-015 SHALL emit 32'h0000_0013 (NOP) with o_err=1 for an opcode outside riscv_op_e.
REQ-016 SHALL have a latency of 1 cycle: a word accepted at edge N is visible on o_valid/o_instr after edge N when the buffer was empty.
REQ-017 SHALL buffer words in a 2-entry in-order FIFO.
REQ-018 SHALL drive o_ready = !full, derived from registered occupancy only (no combinational path from i_ready).
REQ-019 SHALL, at occupancy 1 with simultaneous push and pop, keep occupancy 1 and present the new word next cycle.
REQ-020 SHALL, when empty, never pop.
REQ-021 SHALL, when full, never push.
REQ-022 SHALL hold o_instr and o_err stable while o_valid && !i_ready.
REQ-023 SHALL increment o_err_count on each pop with o_err=1, saturating at 8'hFF with no wrap.

Reset
REQ-024 SHALL, while i_rst_n=0, drive o_valid=0, o_ready=0, o_instr=0, o_err=0 and o_err_count=0, and empty the FIFO.
REQ-025 SHALL raise o_ready on the first edge after reset deassertion.
REQ-026 SHALL, on reset asserted mid-operation, discard buffered words immediately (asynchronously).

Configuration
REQ-027 SHALL, with SPARROW_ENCODE_CHECK_EN defined, also set o_err for out-of-range immediates, while still emitting the truncated word:
- I/S: i_imm is not the sign-extension of i_imm[11:0].
- B: i_imm is not the sign-extension of i_imm[12:0], or imm[0]!=0.
- J: i_imm is not the sign-extension of i_imm[20:0], or imm[0]!=0.
- U: imm[11:0]!=0.
REQ-028 SHALL, without SPARROW_ENCODE_CHECK_EN, set o_err only for an unknown opcode and truncate immediates silently.

Structure
REQ-029 SHALL take riscv_op_e from sparrow_pkg.
REQ-030 SHALL place a new packed struct encode_req_t, grouping the REQ-005 fields, in sparrow_pkg.
REQ-031 SHALL place the NOP constant (32'h0000_0013) in sparrow_pkg.
REQ-032 SHALL implement the 2-entry buffer as one sub-module, sparrow_skid_fifo, parameterised on payload width (33 bits here: instr plus err).
REQ-033 SHALL implement the formatter as combinational logic inside sparrow_encode.

Verification
REQ-034 SHALL cover: I_TYPE_0, rd=1, rs1=0, funct3=0, imm=5 -> o_instr=0x00500093, o_err=0, one cycle after accept.
REQ-035 SHALL cover: S, rs1=1, rs2=2, funct3=2, imm=8 -> 0x0020A423; J, rd=0, imm=-8 -> 0xFF9FF06F; R, rd=3, rs1=1, rs2=2, funct3=0, funct7=0 -> 0x002081B3.
REQ-036 SHALL cover: i_opcode=7'h7F -> o_instr=0x00000013, o_err=1, and o_err_count 0->1 on pop.
REQ-037 SHALL cover: B, imm=3 -> o_err=1 with SPARROW_ENCODE_CHECK_EN and o_err=0 without; U, imm=0x12345001 -> o_err=1 only with the macro.
REQ-038 SHALL cover: i_ready=0 while 3 back-to-back requests are offered -> 2 accepted, o_ready=0, third stalled; i_ready=1 -> words delivered in order with no loss or duplication.
REQ-039 SHALL cover: i_rst_n pulsed low with 2 buffered words -> o_valid=0 immediately, o_err_count=0, and no stale word after release.

Source files
------------

// File: rtl/sparrow_pkg.sv
// sparrow_pkg: shared RV32I opcode classes, encode request struct and NOP constant.
package sparrow_pkg;
  typedef enum logic [6:0] {
    R_TYPE   = 7'h33,
    I_TYPE_0 = 7'h13,
    I_TYPE_1 = 7'h03,
    I_TYPE_2 = 7'h67,
    S_TYPE   = 7'h23,
    B_TYPE   = 7'h63,
    U_TYPE_0 = 7'h37,
    U_TYPE_1 = 7'h17,
    J_TYPE   = 7'h6F
  } riscv_op_e;
  typedef struct packed {
    riscv_op_e   opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } encode_req_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  // True when v equals the sign-extension of v[msb:0].
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned msb);
    logic [31:0] m;
    m = 32'hFFFF_FFFF << msb;
    return ((v & m) == 32'h0) || ((v & m) == m);
  endfunction
endpackage

// File: rtl/sparrow_skid_fifo.sv
// sparrow_skid_fifo: 2-entry in-order valid/ready buffer; in_ready comes from registered state only.
module sparrow_skid_fifo #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [W-1:0] mem [2];
  logic         rd_ptr, wr_ptr, live;
  logic [1:0]   count;
  logic         push, pop;
  assign in_ready  = live && (count != 2'd2);
  assign out_valid = count != 2'd0;
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      live   <= 1'b0;
    end else begin
      live <= 1'b1;
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
endmodule

// File: rtl/sparrow_encode.sv
// sparrow_encode: RV32I instruction formatter feeding a 2-entry output buffer with error counting.
// Optional build macro SPARROW_ENCODE_CHECK_EN flags out-of-range immediates.
module sparrow_encode
  import sparrow_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  riscv_op_e   i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic        o_err,
  output logic [7:0]  o_err_count
);
`ifdef SPARROW_ENCODE_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif
  encode_req_t req;
  logic [31:0] instr;
  logic        bad_op, range_bad, err;
  assign req = '{opcode: i_opcode, rd: i_rd, rs1: i_rs1, rs2: i_rs2,
                 funct3: i_funct3, funct7: i_funct7, imm: i_imm};
  always_comb begin
    instr     = NOP;
    bad_op    = 1'b0;
    range_bad = 1'b0;
    case (req.opcode)
      R_TYPE:
        instr = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
      I_TYPE_0, I_TYPE_1, I_TYPE_2: begin
        instr     = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
        range_bad = !fits_signed(req.imm, 11);
      end
      S_TYPE: begin
        instr     = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.opcode};
        range_bad = !fits_signed(req.imm, 11);
      end
      B_TYPE: begin
        instr     = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                     req.imm[4:1], req.imm[11], req.opcode};
        range_bad = !fits_signed(req.imm, 12) || req.imm[0];
      end
      U_TYPE_0, U_TYPE_1: begin
        instr     = {req.imm[31:12], req.rd, req.opcode};
        range_bad = req.imm[11:0] != 12'h0;
      end
      J_TYPE: begin
        instr     = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12], req.rd, req.opcode};
        range_bad = !fits_signed(req.imm, 20) || req.imm[0];
      end
      default: bad_op = 1'b1;
    endcase
    err = bad_op || (CHECK_EN && range_bad);
  end
  sparrow_skid_fifo #(.W(33)) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .in_valid  (i_valid),
    .in_ready  (o_ready),
    .in_data   ({err, instr}),
    .out_valid (o_valid),
    .out_ready (i_ready),
    .out_data  ({o_err, o_instr})
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) o_err_count <= 8'h00;
    else if (o_valid && i_ready && o_err && o_err_count != 8'hFF) o_err_count <= o_err_count + 8'h01;
endmodule

// File: tb/tb_sparrow_encode.sv
// tb_sparrow_encode: directed self-checking bench for sparrow_encode (honours SPARROW_ENCODE_CHECK_EN).
module tb_sparrow_encode;
  import sparrow_pkg::*;
  logic        i_clk = 1'b0;
  logic        i_rst_n, i_valid, i_ready, o_ready, o_valid, o_err;
  riscv_op_e   i_opcode;
  logic [4:0]  i_rd, i_rs1, i_rs2;
  logic [2:0]  i_funct3;
  logic [6:0]  i_funct7;
  logic [31:0] i_imm, o_instr;
  logic [7:0]  o_err_count;
  int          compared = 0;
  int          mismatched = 0;
`ifdef SPARROW_ENCODE_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  sparrow_encode dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_opcode(i_opcode), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2),
    .i_funct3(i_funct3), .i_funct7(i_funct7), .i_imm(i_imm),
    .o_valid(o_valid), .i_ready(i_ready), .o_instr(o_instr), .o_err(o_err),
    .o_err_count(o_err_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic drive(input riscv_op_e op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm);
    i_opcode = op; i_rd = rd; i_rs1 = rs1; i_rs2 = rs2;
    i_funct3 = f3; i_funct7 = f7; i_imm = imm;
  endtask

  // One request with i_ready high: visible one edge after accept, gone after the pop edge.
  task automatic xfer(input string tag, input logic [31:0] ex_instr, input logic ex_err);
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    chk({tag, "_valid"}, 32'(o_valid), 32'd1);
    chk({tag, "_instr"}, o_instr, ex_instr);
    chk({tag, "_err"}, 32'(o_err), 32'(ex_err));
    tick();
    chk({tag, "_drained"}, 32'(o_valid), 32'd0);
  endtask

  initial begin
    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    drive(I_TYPE_0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    tick(); tick();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_instr", o_instr, 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_cnt", 32'(o_err_count), 32'd0);
    i_rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 32'(o_ready), 32'd1);

    drive(I_TYPE_0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    xfer("addi", 32'h0050_0093, 1'b0);
    drive(I_TYPE_0, 5'd1, 5'd0, 5'd31, 3'd0, 7'h7F, 32'd5);
    xfer("addi_ignore_f7", 32'h0050_0093, 1'b0);
    drive(S_TYPE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    xfer("sw", 32'h0020_A423, 1'b0);
    drive(J_TYPE, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd8);
    xfer("jal", 32'hFF9F_F06F, 1'b0);
    drive(R_TYPE, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    xfer("add", 32'h0020_81B3, 1'b0);
    drive(B_TYPE, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    xfer("b_odd", 32'h0000_0163, CHK);
    drive(U_TYPE_0, 5'd0, 5'd0, 5'd31, 3'd0, 7'd0, 32'h1234_5001);
    xfer("lui_low", 32'h1234_5037, CHK);
    chk("cnt_before_bad", 32'(o_err_count), CHK ? 32'd2 : 32'd0);
    drive(riscv_op_e'(7'h7F), 5'd1, 5'd1, 5'd1, 3'd1, 7'd1, 32'd1);
    xfer("bad_op", 32'h0000_0013, 1'b1);
    chk("cnt_after_bad", 32'(o_err_count), CHK ? 32'd3 : 32'd1);

    // Backpressure: two accepted, third stalled, then ordered drain with push+pop at occupancy 1.
    i_ready = 1'b0;
    drive(I_TYPE_0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    i_valid = 1'b1;
    tick();
    chk("bp_ready1", 32'(o_ready), 32'd1);
    drive(I_TYPE_0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    tick();
    chk("bp_full", 32'(o_ready), 32'd0);
    drive(I_TYPE_0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    tick();
    chk("bp_stall_ready", 32'(o_ready), 32'd0);
    chk("bp_hold_instr", o_instr, 32'h0010_0093);
    i_ready = 1'b1;
    tick();
    chk("bp_w2", o_instr, 32'h0020_0093);
    chk("bp_ready_again", 32'(o_ready), 32'd1);
    tick();
    i_valid = 1'b0;
    chk("bp_w3", o_instr, 32'h0030_0093);
    chk("bp_w3_valid", 32'(o_valid), 32'd1);
    tick();
    chk("bp_empty", 32'(o_valid), 32'd0);

    // Asynchronous reset with two words buffered.
    i_ready = 1'b0;
    drive(I_TYPE_0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    i_valid = 1'b1;
    tick();
    drive(riscv_op_e'(7'h7F), 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    tick();
    i_valid = 1'b0;
    chk("pre_rst_full", 32'(o_ready), 32'd0);
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(o_valid), 32'd0);
    chk("arst_cnt", 32'(o_err_count), 32'd0);
    chk("arst_instr", o_instr, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    tick();
    chk("post_rst_ready", 32'(o_ready), 32'd1);
    chk("post_rst_valid", 32'(o_valid), 32'd0);
    tick();
    chk("post_rst_stale", 32'(o_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
